// File: rtl/timer_pkg.sv
// timer_pkg: shared state type and default widths for the countdown timer.
package timer_pkg;
  typedef enum logic {IDLE, RUN} timer_state_t;
  localparam int TIMER_N = 8;
  localparam int TIMER_PW = 4;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one tick every period+1 enabled cycles; period captured on start (clr & en).
module tick_gen
  import timer_pkg::*;
#(
  parameter int PW = TIMER_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] period,
  output logic          tick
);
  logic [PW-1:0] pc;
  logic [PW-1:0] pr;
  assign tick = en & ~clr & (pc == pr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      pr <= '0;
    end else begin
      if (clr & en) pr <= period;
      pc <= (clr | tick) ? '0 : en ? pc + 1'b1 : pc;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with prescaler, expire pulse and optional auto-reload.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int N = TIMER_N,
  parameter int PW = TIMER_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          start,
  input  logic          stop,
  input  logic          reload_en,
  input  logic [PW-1:0] prescale,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          expire,
  output logic          zero
);
  timer_state_t state;
  logic [N-1:0] rld;
  logic run, stop_ok, start_ok, clr, en, tick;
  assign run = state == RUN;
  assign stop_ok = ~load & stop & run;
  assign start_ok = ~load & start & ~run & (q != '0);
  // prescaler restarts its phase on every load, stop and accepted start
  assign clr = load | stop_ok | start_ok;
  assign en = start_ok | (run & ~load & ~stop);
  assign zero = q == '0;
  tick_gen #(.PW(PW)) u_tick (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .period(prescale), .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      rld <= '0;
      busy <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (load) begin
        q <= d;
        rld <= d;
        state <= IDLE;
        busy <= 1'b0;
      end else if (stop_ok) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (start && !run) begin
        if (q != '0) begin
          state <= RUN;
          busy <= 1'b1;
        end else begin
          expire <= 1'b1;
        end
      end else if (run && tick) begin
        if (q > N'(1)) begin
          q <= q - 1'b1;
        end else if (reload_en && rld != '0) begin
          q <= rld;
          expire <= 1'b1;
        end else begin
          q <= '0;
          expire <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven and directed checks of countdown_timer.
module tb_countdown_timer;
  logic clk = 0, rst_n = 0, load = 0, start = 0, stop = 0, reload_en = 0;
  logic [3:0] prescale = 0;
  logic [7:0] d = 0, q;
  logic busy, expire, zero;
  int tests = 0, fails = 0;

  countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start(start), .stop(stop),
    .reload_en(reload_en), .prescale(prescale), .d(d), .q(q),
    .busy(busy), .expire(expire), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld, st, sp, re;
    logic [3:0] ps;
    logic [7:0] d;
    logic [7:0] eq;
    logic eb, ee, ez;
  } vec_t;
  vec_t tv[16];

  task automatic chk(input string nm, input logic [7:0] eq, input logic eb, ee, ez);
    tests++;
    if (q !== eq || busy !== eb || expire !== ee || zero !== ez) begin
      fails++;
      $display("FAIL %s: got q=%0d busy=%b expire=%b zero=%b, want q=%0d busy=%b expire=%b zero=%b",
               nm, q, busy, expire, zero, eq, eb, ee, ez);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    load = 0; start = 0; stop = 0;
  endtask

  initial begin
    // ld st sp re ps d | q busy expire zero
    tv[0]  = '{1, 0, 0, 0, 0, 5,  5, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 0, 0, 0,  5, 1, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0,  4, 1, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0,  3, 1, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 0,  2, 1, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 1};
    tv[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1};
    tv[8]  = '{1, 0, 0, 0, 0, 9,  9, 0, 0, 0};
    tv[9]  = '{0, 1, 0, 0, 0, 0,  9, 1, 0, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0,  8, 1, 0, 0};
    tv[11] = '{1, 1, 0, 0, 0, 7,  7, 0, 0, 0};
    tv[12] = '{0, 0, 0, 0, 0, 0,  7, 0, 0, 0};
    tv[13] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 1};
    tv[14] = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 1};
    tv[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1};

    #12;
    chk("reset", 0, 0, 0, 1);
    rst_n = 1;
    step();
    for (int i = 0; i < 16; i++) begin
      load = tv[i].ld; start = tv[i].st; stop = tv[i].sp;
      reload_en = tv[i].re; prescale = tv[i].ps; d = tv[i].d;
      step();
      chk($sformatf("vec%0d", i), tv[i].eq, tv[i].eb, tv[i].ee, tv[i].ez);
    end
    idle_in();

    // periodic mode: d=3, P=3, reload on; reload_en cleared after edge 24
    load = 1; d = 3; step(); idle_in();
    start = 1; prescale = 3; reload_en = 1; step(); start = 0;
    chk("per_start", 3, 1, 0, 0);
    for (int e = 1; e <= 36; e++) begin
      if (e == 25) reload_en = 0;
      step();
      if (e < 36)
        chk($sformatf("per_e%0d", e), 8'(3 - ((e / 4) % 3)), 1, (e % 12 == 0), 0);
      else
        chk("per_last", 0, 0, 1, 1);
    end
    step();
    chk("per_after", 0, 0, 0, 1);

    // stop at q=4 while a tick is due, then resume with fresh phase (P=1)
    load = 1; d = 6; step(); idle_in();
    start = 1; prescale = 1; step(); start = 0;
    for (int e = 1; e <= 5; e++) step();
    chk("stop_pre", 4, 1, 0, 0);
    stop = 1; step(); stop = 0;
    chk("stop_hold", 4, 0, 0, 0);
    step(); step();
    chk("stop_idle", 4, 0, 0, 0);
    start = 1; step(); start = 0;
    chk("resume0", 4, 1, 0, 0);
    step();
    chk("resume1", 4, 1, 0, 0);
    step();
    chk("resume2", 3, 1, 0, 0);

    // all-ones prescale gives period 16; then async reset mid-run at q=200
    load = 1; d = 200; step(); idle_in();
    start = 1; prescale = 15; step(); start = 0;
    for (int e = 1; e <= 15; e++) step();
    chk("ps_max15", 200, 1, 0, 0);
    step();
    chk("ps_max16", 199, 1, 0, 0);
    load = 1; d = 200; step(); load = 0;
    start = 1; step(); start = 0;
    step(); step();
    #2 rst_n = 0;
    #1 chk("async_rst", 0, 0, 0, 1);
    step();
    chk("rst_hold", 0, 0, 0, 1);
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer: the decrementing counterpart to the team's loadable up-counter. Software or a control FSM loads a count, starts it, and receives a one-cycle `expire` pulse when the count reaches zero, with optional auto-reload for periodic events. A programmable prescaler sets the decrement rate. The block sits beside the program counter in the ch2 datapath as its timing and interrupt source.

## Interface
- `N`, 8: count width.
- `PW`, 4: prescaler width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: load `d` into `q` and into the reload register `rld`.
- `start` in 1: begin counting from current `q`.
- `stop` in 1: halt counting; `q` holds.
- `reload_en` in 1: auto-reload on expiry; sampled live.
- `prescale` in PW: one decrement every `prescale+1` cycles; captured on `start`.
- `d` in N: load value.
- `q` out N: current count.
- `busy` out 1: high while in RUN.
- `expire` out 1: one-cycle pulse on expiry; registered.
- `zero` out 1: combinational `q == 0`.

## Operation
- States are IDLE and RUN.
- Reset values: `q=0`, `rld=0`, prescale register 0, prescaler count `pc=0`, state IDLE, `busy=0`, `expire=0`, `zero=1`.
- Per-edge priority is `load` > `stop` > `start` > tick.
- `load`, in any state: `q<=d`, `rld<=d`, `pc<=0`, state goes to IDLE, and `start` in the same cycle is ignored.
- `stop` in RUN: state goes to IDLE, `q` holds, `pc<=0`. `stop` in IDLE has no effect.
- `start` in IDLE with `q!=0`: state goes to RUN, `pc<=0`, the prescale register is loaded from `prescale`.
- `start` in IDLE with `q==0`: `expire` pulses for 1 cycle, state stays IDLE.
- `start` in RUN is ignored: no restart.
- Tick: occurs in RUN when `pc == prescale register`. On a tick `pc<=0`; otherwise `pc<=pc+1`.
- Tick with `q>1`: `q<=q-1`.
- Tick with `q==1` and (`reload_en==0` or `rld==0`): `q<=0`, `expire<=1`, state goes to IDLE.
- Tick with `q==1`, `reload_en==1` and `rld!=0`: `q<=rld`, `expire<=1`, state stays RUN. In this case `q` never shows 0.
- Width rules:
  - `q` never wraps below 0; decrement only occurs when `q>=1`.
  - `pc` is PW bits, so `prescale` = all-ones gives a period of 2^PW.
- Reset asserted mid-RUN: all state returns to reset values immediately, and `expire` is dropped.

## Timing
- Edge numbering: the edge that samples `start` is edge 0; `busy` is high after edge 0.
- With prescale register P, decrements occur at edges k·(P+1) for k=1,2,…
- A loaded value V reaches 0 (or reloads) at edge V·(P+1).
- `expire` is high for exactly the cycle following that edge. In one-shot mode this coincides with `q==0` and `busy==0`.
- Load latency: `q` shows `d` after 1 edge.
- Stop latency: `busy` falls after 1 edge, with no further decrement at that edge even if a tick was due.
- Periodic mode: the expire period is `rld·(P+1)` cycles with no gap cycle.

## Structure
- Package `timer_pkg`:
  - state enum `timer_state_t` {IDLE, RUN};
  - default widths `TIMER_N=8`, `TIMER_PW=4`.
- Sub-module `tick_gen #(PW)`:
  - inputs: `clk`, `rst_n`, `clr`, `en`, `period[PW-1:0]`;
  - output: `tick`;
  - contains `pc` and the captured prescale register (captured on `clr & en`-start).
- The top level holds the FSM, `q`, `rld` and `expire`.

## Test plan
- Reset, then `load` with `d=5`, then `start` with `prescale=0` and `reload_en=0`: `q` goes 5,4,3,2,1,0 on consecutive edges; `expire` is high one cycle with `q==0`; `busy` falls at the same edge.
- `load` with `d=3`, `prescale=3`, `reload_en=1`: `q` decrements every 4 cycles; `expire` pulses every 12 cycles and `q` returns to 3 without showing 0; clear `reload_en` mid-run, then the next expiry leaves `q=0` and IDLE.
- `stop` mid-count at `q=4`: `q` holds 4 and `busy=0`; re-`start` resumes from 4 with a fresh prescale phase.
- `load` and `start` asserted in the same cycle, with `d=7` during RUN: `q=7`, IDLE, `busy=0`, no `expire`.
- `start` with `q=0`: a single `expire` pulse, `busy` stays 0.
- `rst_n` dropped asynchronously mid-RUN at `q=200`: `q=0`, `busy=0`, `expire=0` immediately; `zero=1`.
